uart_tx_serializer: RTL and testbench
=====================================

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Parameters
REQ-001 DATA_WIDTH, default 8, number of data bits per frame (legal 5..9).
REQ-002 CLKS_PER_BIT, default 1736 (200 MHz / 115200 baud), i_clk cycles per serial bit (legal >= 2).

Interface
REQ-003 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-004 i_rst  in  1  asynchronous, active-high reset.
REQ-005 i_P_DATA  in  DATA_WIDTH  parallel byte from the TX host.
REQ-006 i_latch_en  in  1  one-cycle pulse from the FSM controller that captures i_P_DATA.
REQ-007 i_ser_en  in  1  level from the FSM controller; high for the whole data-bit phase.
REQ-008 i_PAR_TYP  in  1  parity type: 0 = even, 1 = odd.
REQ-009 o_ser_data  out  1  current serial data bit (LSB first).
REQ-010 o_ser_done  out  1  one-cycle pulse when the last data bit period ends.
REQ-011 o_par_bit  out  1  parity of the latched byte, stable from the cycle after the latch until the next latch.
REQ-012 o_bit_tick  out  1  one-cycle pulse at the end of every bit period while in SHIFT.

Function
REQ-013 States: IDLE, LOADED, SHIFT.
REQ-014 IDLE or LOADED, i_latch_en=1: shift_reg <= i_P_DATA; o_par_bit <= XOR(i_P_DATA) XOR i_PAR_TYP; next state LOADED.
REQ-015 i_latch_en while in SHIFT: ignored; shift_reg and o_par_bit are unchanged.
REQ-016 LOADED, i_ser_en=1: next state SHIFT; baud_cnt <= 0; bit_cnt <= 0.
REQ-017 i_ser_en=1 while in IDLE (nothing latched): ignored; o_ser_done is never asserted.
REQ-018 SHIFT: o_ser_data = shift_reg[0] (registered), held for exactly CLKS_PER_BIT cycles per bit.
REQ-019 SHIFT: baud_cnt counts 0..CLKS_PER_BIT-1 and wraps to 0.
  - At wrap: o_bit_tick=1, shift_reg shifts right by 1, bit_cnt increments.
REQ-020 Wrap with bit_cnt = DATA_WIDTH-1: o_ser_done=1 and o_bit_tick=1 in that same cycle; next state IDLE.
REQ-021 Total SHIFT duration: DATA_WIDTH*CLKS_PER_BIT cycles from the first cycle o_ser_data shows bit 0 to the cycle after the o_ser_done pulse.
REQ-022 o_ser_data = 1 (line idle level) in IDLE and in LOADED.
REQ-023 i_ser_en dropping to 0 in SHIFT: frame abort.
  - Next state IDLE; baud_cnt and bit_cnt cleared; o_ser_data=1.
  - No o_ser_done pulse.
REQ-024 i_ser_en falling in the same cycle as the final wrap: o_ser_done still pulses (wrap takes priority).
REQ-025 Counter widths: baud_cnt is clog2(CLKS_PER_BIT) bits; bit_cnt is clog2(DATA_WIDTH+1) bits; no counter overflows.
REQ-026 o_ser_done and o_bit_tick are registered outputs; each is never high for more than one cycle.

Reset
REQ-027 i_rst=1 asynchronously forces:
  - state IDLE; shift_reg=0; baud_cnt=0; bit_cnt=0;
  - o_ser_data=1; o_ser_done=0; o_par_bit=0; o_bit_tick=0.
REQ-028 Reset mid-SHIFT: the frame is discarded; after release the block waits in IDLE for a new i_latch_en.

Verification (CLKS_PER_BIT=4, DATA_WIDTH=8)
REQ-029 Latch 0xA5, PAR_TYP=0, then ser_en=1 -> o_ser_data = 1,0,1,0,0,1,0,1, each held 4 cycles; o_par_bit=0; 8 o_bit_tick pulses; o_ser_done pulses at cycle 32 of SHIFT.
REQ-030 Latch 0x07, PAR_TYP=1 -> o_par_bit=0; latch 0x03, PAR_TYP=1 -> o_par_bit=1.
REQ-031 Latch 0xFF during SHIFT of 0x00 -> serial stream stays all 0s; o_par_bit keeps the 0x00 value.
REQ-032 Drop ser_en after 3 bits -> o_ser_data=1 on the next cycle; no o_ser_done; a subsequent latch+ser_en sends the full new byte.
REQ-033 Assert i_rst asynchronously mid-bit (between clock edges) -> all outputs take their reset values immediately; ser_en alone after release produces no o_ser_done.
REQ-034 Back-to-back: latch the next byte in the cycle o_ser_done is high, then ser_en -> second frame has identical timing; no lost or duplicated bits.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: captures a parallel word, computes its parity and
// shifts it out LSB first, one bit per CLKS_PER_BIT clocks, under controller handshakes.
module uart_tx_serializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1736
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_P_DATA,
    input  logic                  i_latch_en,
    input  logic                  i_ser_en,
    input  logic                  i_PAR_TYP,
    output logic                  o_ser_data,
    output logic                  o_ser_done,
    output logic                  o_par_bit,
    output logic                  o_bit_tick
);

    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOADED = 2'd1;
    localparam logic [1:0] ST_SHIFT  = 2'd2;

    function automatic logic parity_f(input logic [DATA_WIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    logic [1:0]            state_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [BAUD_W-1:0]     baud_cnt_r;
    logic [BIT_W-1:0]      bit_cnt_r;
    logic                  ser_data_r;
    logic                  ser_done_r;
    logic                  par_bit_r;
    logic                  bit_tick_r;

    logic [1:0]            state_nxt_s;
    logic [DATA_WIDTH-1:0] shift_nxt_s;
    logic [BAUD_W-1:0]     baud_cnt_nxt_s;
    logic [BIT_W-1:0]      bit_cnt_nxt_s;
    logic                  ser_data_nxt_s;
    logic                  ser_done_nxt_s;
    logic                  par_bit_nxt_s;
    logic                  bit_tick_nxt_s;
    logic                  baud_wrap_s;
    logic                  baud_pre_s;
    logic                  last_bit_s;

    // Next-state and next-output computation for the serializer FSM.
    always_comb begin
        state_nxt_s    = state_r;
        shift_nxt_s    = shift_r;
        baud_cnt_nxt_s = baud_cnt_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        ser_data_nxt_s = 1'b1;
        ser_done_nxt_s = 1'b0;
        par_bit_nxt_s  = par_bit_r;
        bit_tick_nxt_s = 1'b0;
        baud_wrap_s    = (baud_cnt_r == BAUD_LAST);
        baud_pre_s     = (baud_cnt_r == BAUD_PRE);
        last_bit_s     = (bit_cnt_r == BIT_LAST);

        case (state_r)
            ST_IDLE, ST_LOADED: begin
                if (i_latch_en) begin
                    shift_nxt_s   = i_P_DATA;
                    par_bit_nxt_s = parity_f(i_P_DATA, i_PAR_TYP);
                    state_nxt_s   = ST_LOADED;
                end else if ((state_r == ST_LOADED) && i_ser_en) begin
                    state_nxt_s    = ST_SHIFT;
                    baud_cnt_nxt_s = {BAUD_W{1'b0}};
                    bit_cnt_nxt_s  = {BIT_W{1'b0}};
                    ser_data_nxt_s = shift_r[0];
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_SHIFT: begin
                if (baud_wrap_s && last_bit_s) begin
                    // Final wrap wins over an abort; a latch here chains the next frame.
                    baud_cnt_nxt_s = {BAUD_W{1'b0}};
                    bit_cnt_nxt_s  = {BIT_W{1'b0}};
                    if (i_latch_en) begin
                        shift_nxt_s   = i_P_DATA;
                        par_bit_nxt_s = parity_f(i_P_DATA, i_PAR_TYP);
                        state_nxt_s   = ST_LOADED;
                    end else begin
                        shift_nxt_s = {1'b0, shift_r[DATA_WIDTH-1:1]};
                        state_nxt_s = ST_IDLE;
                    end
                end else if (!i_ser_en) begin
                    state_nxt_s    = ST_IDLE;
                    baud_cnt_nxt_s = {BAUD_W{1'b0}};
                    bit_cnt_nxt_s  = {BIT_W{1'b0}};
                end else if (baud_wrap_s) begin
                    baud_cnt_nxt_s = {BAUD_W{1'b0}};
                    bit_cnt_nxt_s  = bit_cnt_r + BIT_W'(1);
                    shift_nxt_s    = {1'b0, shift_r[DATA_WIDTH-1:1]};
                    ser_data_nxt_s = shift_r[1];
                end else begin
                    // Pulses are registered one cycle early so they cover the last cycle of the bit.
                    baud_cnt_nxt_s = baud_cnt_r + BAUD_W'(1);
                    ser_data_nxt_s = shift_r[0];
                    if (baud_pre_s) begin
                        bit_tick_nxt_s = 1'b1;
                        ser_done_nxt_s = last_bit_s;
                    end else begin
                        bit_tick_nxt_s = 1'b0;
                        ser_done_nxt_s = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                baud_cnt_nxt_s = {BAUD_W{1'b0}};
                bit_cnt_nxt_s  = {BIT_W{1'b0}};
            end
        endcase
    end

    // State and output registers with asynchronous reset to the idle line level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r    <= ST_IDLE;
            shift_r    <= {DATA_WIDTH{1'b0}};
            baud_cnt_r <= {BAUD_W{1'b0}};
            bit_cnt_r  <= {BIT_W{1'b0}};
            ser_data_r <= 1'b1;
            ser_done_r <= 1'b0;
            par_bit_r  <= 1'b0;
            bit_tick_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            shift_r    <= shift_nxt_s;
            baud_cnt_r <= baud_cnt_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            ser_data_r <= ser_data_nxt_s;
            ser_done_r <= ser_done_nxt_s;
            par_bit_r  <= par_bit_nxt_s;
            bit_tick_r <= bit_tick_nxt_s;
        end
    end

    assign o_ser_data = ser_data_r;
    assign o_ser_done = ser_done_r;
    assign o_par_bit  = par_bit_r;
    assign o_bit_tick = bit_tick_r;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer (CLKS_PER_BIT=4, DATA_WIDTH=8):
// parity table, directed frames, abort/reset/back-to-back cases and random frames.
module tb_uart_tx_serializer;

    localparam int CPB = 4;
    localparam int DW  = 8;

    logic          clk;
    logic          rst;
    logic [DW-1:0] p_data;
    logic          latch_en;
    logic          ser_en;
    logic          par_typ;
    logic          ser_data;
    logic          ser_done;
    logic          par_bit;
    logic          bit_tick;

    int total;
    int bad;

    typedef struct {
        logic [7:0] data;
        logic       typ;
        logic       exp_par;
    } par_vec_t;

    par_vec_t vecs [6];

    uart_tx_serializer #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_P_DATA   (p_data),
        .i_latch_en (latch_en),
        .i_ser_en   (ser_en),
        .i_PAR_TYP  (par_typ),
        .o_ser_data (ser_data),
        .o_ser_done (ser_done),
        .o_par_bit  (par_bit),
        .o_bit_tick (bit_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s t=%0t actual=%b expected=%b", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic model_par(input logic [7:0] d, input logic t);
        return logic'(($countones(d) % 2) != 0) ^ t;
    endfunction

    task automatic check_idle(input string tag, input logic exp_par);
        check({tag, "_ser"}, ser_data, 1'b1);
        check({tag, "_done"}, ser_done, 1'b0);
        check({tag, "_tick"}, bit_tick, 1'b0);
        check({tag, "_par"}, par_bit, exp_par);
    endtask

    // One frame; abort_k / intr_k of 99 disable those events, chain latches nd at the done cycle.
    task automatic run_frame(input logic [7:0] d, input logic t, input int abort_k,
                             input int intr_k, input logic chain, input logic [7:0] nd,
                             input logic nt, input logic prelatched);
        logic exp_par;
        logic act;
        int   last_k;
        exp_par = model_par(d, t);
        if (!prelatched) begin
            p_data   = d;
            par_typ  = t;
            latch_en = 1'b1;
            ser_en   = 1'b0;
            step();
        end
        latch_en = 1'b0;
        check_idle("loaded", exp_par);
        ser_en = 1'b1;
        step();
        last_k = chain ? 31 : 35;
        for (int k = 0; k <= last_k; k++) begin
            act = (k <= abort_k) && (k < 32);
            check("ser_data", ser_data, act ? d[k / CPB] : 1'b1);
            check("bit_tick", bit_tick, act && ((k % CPB) == CPB - 1));
            check("ser_done", ser_done, act && (k == 31));
            check("par_hold", par_bit, exp_par);
            latch_en = 1'b0;
            if (k == intr_k) begin
                latch_en = 1'b1;
                p_data   = ~d;
                par_typ  = ~t;
            end
            if (chain && k == 31) begin
                latch_en = 1'b1;
                p_data   = nd;
                par_typ  = nt;
            end
            if (k == abort_k) ser_en = 1'b0;
            step();
        end
        latch_en = 1'b0;
        if (!chain) ser_en = 1'b0;
    endtask

    initial begin
        logic [7:0] cur_d;
        logic [7:0] nd;
        logic       cur_t;
        logic       nt;
        logic       chained;
        logic       do_chain;
        int         ab;
        int         intr;

        total = 0;
        bad   = 0;
        vecs[0] = '{data: 8'hA5, typ: 1'b0, exp_par: 1'b0};
        vecs[1] = '{data: 8'h07, typ: 1'b1, exp_par: 1'b0};
        vecs[2] = '{data: 8'h03, typ: 1'b1, exp_par: 1'b1};
        vecs[3] = '{data: 8'hFF, typ: 1'b0, exp_par: 1'b0};
        vecs[4] = '{data: 8'h00, typ: 1'b1, exp_par: 1'b1};
        vecs[5] = '{data: 8'h01, typ: 1'b0, exp_par: 1'b1};

        clk      = 1'b0;
        rst      = 1'b1;
        p_data   = 8'h00;
        latch_en = 1'b0;
        ser_en   = 1'b0;
        par_typ  = 1'b0;
        #12;
        check_idle("reset", 1'b0);
        step();
        rst = 1'b0;

        // ser_en with nothing latched must be ignored
        ser_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check_idle("idle_seren", 1'b0);
        end
        ser_en = 1'b0;

        for (int i = 0; i < 6; i++) begin
            p_data   = vecs[i].data;
            par_typ  = vecs[i].typ;
            latch_en = 1'b1;
            step();
            latch_en = 1'b0;
            check_idle("par_table", vecs[i].exp_par);
        end

        run_frame(8'hA5, 1'b0, 99, 99, 1'b0, 8'h00, 1'b0, 1'b0);
        run_frame(8'h00, 1'b0, 99, 5, 1'b0, 8'h00, 1'b0, 1'b0);
        run_frame(8'h3C, 1'b1, 11, 99, 1'b0, 8'h00, 1'b0, 1'b0);
        run_frame(8'hC3, 1'b0, 99, 99, 1'b0, 8'h00, 1'b0, 1'b0);
        run_frame(8'h5A, 1'b0, 99, 99, 1'b1, 8'h96, 1'b1, 1'b0);
        run_frame(8'h96, 1'b1, 99, 99, 1'b0, 8'h00, 1'b0, 1'b1);

        // asynchronous reset while a tick is high, then ser_en alone
        p_data   = 8'hA4;
        par_typ  = 1'b0;
        latch_en = 1'b1;
        step();
        latch_en = 1'b0;
        check("rst_pre_par", par_bit, 1'b1);
        ser_en = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("rst_pre_tick", bit_tick, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_rst", 1'b0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            check_idle("post_rst", 1'b0);
        end
        ser_en = 1'b0;

        chained = 1'b0;
        cur_d   = 8'($urandom);
        cur_t   = 1'($urandom_range(0, 1));
        for (int i = 0; i < 24; i++) begin
            ab       = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : 99;
            do_chain = (ab == 99) && ($urandom_range(0, 3) == 0) && (i < 23);
            intr     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : 99;
            if (intr >= ab) intr = 99;
            nd = 8'($urandom);
            nt = 1'($urandom_range(0, 1));
            run_frame(cur_d, cur_t, ab, intr, do_chain, nd, nt, chained);
            chained = do_chain;
            cur_d   = do_chain ? nd : 8'($urandom);
            cur_t   = do_chain ? nt : 1'($urandom_range(0, 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
